// File: rtl/enytank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enytank_pkg
// Description : Shared encodings for the enemy-tank controller: movement and
//               fire directions, controller states and spawn-corner selects.
// Revision    : 1.0 - initial release
// ============================================================================
package enytank_pkg;

    // Direction encoding shared by tank_dir_out and fire_dir (y decreasing = up)
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Spawn-corner selects carried on tank_num
    localparam logic [1:0] CORNER_X0_Y0 = 2'd0;
    localparam logic [1:0] CORNER_XM_Y0 = 2'd1;
    localparam logic [1:0] CORNER_X0_YM = 2'd2;
    localparam logic [1:0] CORNER_XM_YM = 2'd3;

    // Controller life-cycle states
    typedef enum logic [1:0] {
        ST_DEAD  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_ALIVE = 2'd2,
        ST_DYING = 2'd3
    } state_e;

endpackage : enytank_pkg
`default_nettype wire

// File: rtl/enytank_chase.sv
`default_nettype none
// ============================================================================
// Module      : enytank_chase
// Description : Combinational chase step. Given enemy and player coordinates
//               it proposes the next enemy position one cell toward the
//               player (shorter axis first, y on a tie), the direction of
//               that step, and whether the two tanks share exactly one axis.
// Revision    : 1.0 - initial release
// ============================================================================
module enytank_chase #(
    parameter int XW    = 5,
    parameter int YW    = 5,
    parameter int X_MAX = 24,
    parameter int Y_MAX = 12
) (
    input  logic [XW-1:0] ex_i,
    input  logic [YW-1:0] ey_i,
    input  logic [XW-1:0] mx_i,
    input  logic [YW-1:0] my_i,
    output logic [XW-1:0] nx_o,
    output logic [YW-1:0] ny_o,
    output logic [1:0]    dir_o,
    output logic          same_o,
    output logic          aligned_o
);
    import enytank_pkg::*;

    localparam logic [XW-1:0] XMAX_C = XW'(X_MAX);
    localparam logic [YW-1:0] YMAX_C = YW'(Y_MAX);

    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic          step_x;

    // Distance, axis choice and bounded single-cell step toward the player
    always_comb begin
        dx        = (ex_i > mx_i) ? (ex_i - mx_i) : (mx_i - ex_i);
        dy        = (ey_i > my_i) ? (ey_i - my_i) : (my_i - ey_i);
        step_x    = (dx != '0) && ((dy == '0) || (dx < dy));
        same_o    = (dx == '0) && (dy == '0);
        aligned_o = (dx == '0) ^ (dy == '0);
        nx_o      = ex_i;
        ny_o      = ey_i;
        dir_o     = DIR_DOWN;
        if (!same_o) begin
            if (step_x) begin
                if (mx_i > ex_i) begin
                    dir_o = DIR_RIGHT;
                    if (ex_i < XMAX_C) nx_o = ex_i + 1'b1;
                end else begin
                    dir_o = DIR_LEFT;
                    if (ex_i != '0) nx_o = ex_i - 1'b1;
                end
            end else begin
                if (my_i > ey_i) begin
                    dir_o = DIR_DOWN;
                    if (ey_i < YMAX_C) ny_o = ey_i + 1'b1;
                end else begin
                    dir_o = DIR_UP;
                    if (ey_i != '0) ny_o = ey_i - 1'b1;
                end
            end
        end
    end

endmodule : enytank_chase
`default_nettype wire

// File: rtl/enytank_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : enytank_ctrl_v2
// Description : Enemy-tank controller. Spawns at a selected corner, chases
//               the player on move_tick, requests bullet launches over a
//               req/ack handshake when lined up, and scores kills with a
//               post-spawn guard window and a timed kill indicator.
//               Optional macro ENYTANK_LASER_EN: the player's laser reward
//               kills the tank when it lies on the player's facing ray.
// Revision    : 1.0 - initial release
// ============================================================================
module enytank_ctrl_v2 #(
    parameter int XW          = 5,
    parameter int YW          = 5,
    parameter int X_MAX       = 24,
    parameter int Y_MAX       = 12,
    parameter int SCORE_W     = 7,
    parameter int KILL_HOLD   = 5000000,
    parameter int SPAWN_GUARD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               move_tick,
    input  logic               tank_en,
    input  logic [1:0]         tank_num,
    input  logic [XW-1:0]      mytank_xpos,
    input  logic [YW-1:0]      mytank_ypos,
    input  logic [1:0]         mytank_dir,
    input  logic               mybul_valid,
    input  logic [XW-1:0]      mybul_x,
    input  logic [YW-1:0]      mybul_y,
    input  logic               reward_frozen,
    input  logic               reward_laser,
    input  logic               bul_busy,
    input  logic               fire_ack,
    output logic               fire_req,
    output logic [1:0]         fire_dir,
    output logic               tank_state,
    output logic [XW-1:0]      enytank_xpos,
    output logic [YW-1:0]      enytank_ypos,
    output logic [1:0]         tank_dir_out,
    output logic               kill,
    output logic [SCORE_W-1:0] score
);
    import enytank_pkg::*;

    localparam int HW = (KILL_HOLD > 1) ? $clog2(KILL_HOLD) : 1;
    localparam int GW = (SPAWN_GUARD > 0) ? $clog2(SPAWN_GUARD + 1) : 1;

    state_e               state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [1:0]           dir_q, dir_d;
    logic                 fire_req_q, fire_req_d;
    logic [1:0]           fire_dir_q, fire_dir_d;
    logic                 ack_blk_q, ack_blk_d;
    logic                 kill_q, kill_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [GW-1:0]        guard_q, guard_d;
    logic [HW-1:0]        hold_q, hold_d;

    logic [XW-1:0]        chase_x;
    logic [YW-1:0]        chase_y;
    logic [1:0]           chase_dir;
    logic                 same_pos;
    logic                 aligned;
    logic                 laser_hit;
    logic                 hit;

    enytank_chase #(
        .XW    (XW),
        .YW    (YW),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_chase (
        .ex_i      (x_q),
        .ey_i      (y_q),
        .mx_i      (mytank_xpos),
        .my_i      (mytank_ypos),
        .nx_o      (chase_x),
        .ny_o      (chase_y),
        .dir_o     (chase_dir),
        .same_o    (same_pos),
        .aligned_o (aligned)
    );

`ifdef ENYTANK_LASER_EN
    // Tank lies on the player's facing ray while the laser reward is active
    always_comb begin
        laser_hit = 1'b0;
        case (mytank_dir)
            DIR_UP:    laser_hit = (x_q == mytank_xpos) && (y_q < mytank_ypos);
            DIR_DOWN:  laser_hit = (x_q == mytank_xpos) && (y_q > mytank_ypos);
            DIR_LEFT:  laser_hit = (y_q == mytank_ypos) && (x_q < mytank_xpos);
            default:   laser_hit = (y_q == mytank_ypos) && (x_q > mytank_xpos);
        endcase
        laser_hit = laser_hit && reward_laser;
    end
`else
    assign laser_hit = 1'b0;
    logic unused_laser;
    assign unused_laser = ^{reward_laser, mytank_dir};
`endif

    assign hit = ((x_q == mytank_xpos) && (y_q == mytank_ypos))
               || (mybul_valid && (x_q == mybul_x) && (y_q == mybul_y))
               || laser_hit;

    // Next-state, movement, fire handshake and scoring decisions
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        fire_req_d = fire_req_q;
        fire_dir_d = fire_dir_q;
        ack_blk_d  = 1'b0;
        kill_d     = kill_q;
        score_d    = score_q;
        guard_d    = guard_q;
        hold_d     = hold_q;
        if (!enable) begin
            // Soft clear: everything but position and heading returns to reset
            state_d    = ST_DEAD;
            fire_req_d = 1'b0;
            fire_dir_d = DIR_UP;
            kill_d     = 1'b0;
            score_d    = '0;
            guard_d    = '0;
            hold_d     = '0;
        end else begin
            case (state_q)
                ST_DEAD: begin
                    fire_req_d = 1'b0;
                    if (tank_en) state_d = ST_SPAWN;
                end
                ST_SPAWN: begin
                    x_d     = tank_num[0] ? XW'(X_MAX) : '0;
                    y_d     = tank_num[1] ? YW'(Y_MAX) : '0;
                    dir_d   = DIR_DOWN;
                    guard_d = GW'(SPAWN_GUARD);
                    state_d = ST_ALIVE;
                end
                ST_ALIVE: begin
                    if (hit) begin
                        // A hit pre-empts movement and abandons any pending launch
                        state_d    = ST_DYING;
                        fire_req_d = 1'b0;
                        if (guard_q == '0) begin
                            score_d = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + 1'b1;
                            kill_d  = 1'b1;
                            hold_d  = HW'(KILL_HOLD - 1);
                        end else begin
                            kill_d  = 1'b0;
                            hold_d  = '0;
                        end
                    end else begin
                        if (move_tick) begin
                            if (guard_q != '0) guard_d = guard_q - 1'b1;
                            if (!reward_frozen && !same_pos) begin
                                x_d   = chase_x;
                                y_d   = chase_y;
                                dir_d = chase_dir;
                            end
                        end
                        // Request held until acked; one idle cycle after every ack
                        if (fire_req_q) begin
                            if (fire_ack) begin
                                fire_req_d = 1'b0;
                                ack_blk_d  = 1'b1;
                            end
                        end else if (!ack_blk_q && aligned && !bul_busy) begin
                            fire_req_d = 1'b1;
                            fire_dir_d = chase_dir;
                        end
                    end
                end
                default: begin
                    // ST_DYING: run the kill-hold timer out, then return to DEAD
                    fire_req_d = 1'b0;
                    if (hold_q == '0) begin
                        kill_d  = 1'b0;
                        state_d = ST_DEAD;
                    end else begin
                        hold_d  = hold_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_DEAD;
            x_q        <= '0;
            y_q        <= '0;
            dir_q      <= DIR_DOWN;
            fire_req_q <= 1'b0;
            fire_dir_q <= DIR_UP;
            ack_blk_q  <= 1'b0;
            kill_q     <= 1'b0;
            score_q    <= '0;
            guard_q    <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            fire_req_q <= fire_req_d;
            fire_dir_q <= fire_dir_d;
            ack_blk_q  <= ack_blk_d;
            kill_q     <= kill_d;
            score_q    <= score_d;
            guard_q    <= guard_d;
            hold_q     <= hold_d;
        end
    end

    assign fire_req     = fire_req_q;
    assign fire_dir     = fire_dir_q;
    assign tank_state   = (state_q == ST_ALIVE);
    assign enytank_xpos = x_q;
    assign enytank_ypos = y_q;
    assign tank_dir_out = dir_q;
    assign kill         = kill_q;
    assign score        = score_q;

endmodule : enytank_ctrl_v2
`default_nettype wire

// File: tb/tb_enytank_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_enytank_ctrl_v2
// Description : Self-checking bench for enytank_ctrl_v2 (KILL_HOLD = 8).
//               Expectations are queued when stimulus is applied and checked
//               one cycle later; a chase vector table plus hand sequences for
//               handshake, guard, hold, saturation, reset and laser cases.
//               Laser expectations follow macro ENYTANK_LASER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enytank_ctrl_v2;

    localparam int SEL_STATE = 0, SEL_X = 1, SEL_Y = 2, SEL_DIR = 3;
    localparam int SEL_FREQ = 4, SEL_FDIR = 5, SEL_KILL = 6, SEL_SCORE = 7;

    logic       clk = 1'b0;
    logic       rst_n, enable, move_tick, tank_en;
    logic [1:0] tank_num, mytank_dir;
    logic [4:0] mytank_xpos, mytank_ypos, mybul_x, mybul_y;
    logic       mybul_valid, reward_frozen, reward_laser, bul_busy, fire_ack;
    logic       fire_req, tank_state, kill;
    logic [1:0] fire_dir, tank_dir_out;
    logic [4:0] enytank_xpos, enytank_ypos;
    logic [6:0] score;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int    sel;
        int    val;
        string name;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int mx;
        int my;
        int tick;
        int frz;
        int ex;
        int ey;
        int dir;
    } vec_t;
    vec_t tbl[11];

    enytank_ctrl_v2 #(.KILL_HOLD(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .move_tick    (move_tick),
        .tank_en      (tank_en),
        .tank_num     (tank_num),
        .mytank_xpos  (mytank_xpos),
        .mytank_ypos  (mytank_ypos),
        .mytank_dir   (mytank_dir),
        .mybul_valid  (mybul_valid),
        .mybul_x      (mybul_x),
        .mybul_y      (mybul_y),
        .reward_frozen(reward_frozen),
        .reward_laser (reward_laser),
        .bul_busy     (bul_busy),
        .fire_ack     (fire_ack),
        .fire_req     (fire_req),
        .fire_dir     (fire_dir),
        .tank_state   (tank_state),
        .enytank_xpos (enytank_xpos),
        .enytank_ypos (enytank_ypos),
        .tank_dir_out (tank_dir_out),
        .kill         (kill),
        .score        (score)
    );

    always #5 clk = ~clk;

    function automatic int get_out(input int sel);
        case (sel)
            SEL_STATE: return int'(tank_state);
            SEL_X:     return int'(enytank_xpos);
            SEL_Y:     return int'(enytank_ypos);
            SEL_DIR:   return int'(tank_dir_out);
            SEL_FREQ:  return int'(fire_req);
            SEL_FDIR:  return int'(fire_dir);
            SEL_KILL:  return int'(kill);
            default:   return int'(score);
        endcase
    endfunction

    task automatic push(input int sel, input int val, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    // One clock edge, then retire every queued expectation
    task automatic step();
        exp_t e;
        int   act;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = get_out(e.sel);
            total++;
            if (act != e.val) begin
                bad++;
                $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, act, e.val, $time);
            end
        end
    endtask

    task automatic push_reset(input string tag);
        push(SEL_STATE, 0, {tag, "_state"});
        push(SEL_X,     0, {tag, "_x"});
        push(SEL_Y,     0, {tag, "_y"});
        push(SEL_DIR,   1, {tag, "_dir"});
        push(SEL_FREQ,  0, {tag, "_fire_req"});
        push(SEL_KILL,  0, {tag, "_kill"});
        push(SEL_SCORE, 0, {tag, "_score"});
    endtask

    task automatic spawn(input logic [1:0] corner);
        tank_num = corner;
        tank_en  = 1'b1;
        step();
        tank_en  = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            move_tick = 1'b1;
            step();
        end
        move_tick = 1'b0;
    endtask

    task automatic bullet(input logic on, input logic [4:0] bx, input logic [4:0] by);
        mybul_valid = on;
        mybul_x     = bx;
        mybul_y     = by;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Chase table from (0,0): player position, tick, frozen -> enemy x, y, dir
        tbl[0]  = '{3, 7, 1, 0, 1, 0, 3};
        tbl[1]  = '{3, 7, 1, 0, 2, 0, 3};
        tbl[2]  = '{3, 7, 1, 0, 3, 0, 3};
        tbl[3]  = '{3, 7, 1, 0, 3, 1, 1};
        tbl[4]  = '{3, 7, 1, 1, 3, 1, 1};
        tbl[5]  = '{3, 7, 0, 0, 3, 1, 1};
        tbl[6]  = '{1, 1, 1, 0, 2, 1, 2};
        tbl[7]  = '{2, 4, 1, 0, 2, 2, 1};
        tbl[8]  = '{4, 0, 1, 0, 2, 1, 0};
        tbl[9]  = '{4, 0, 1, 0, 2, 0, 0};
        tbl[10] = '{4, 0, 1, 0, 3, 0, 3};

        rst_n = 1'b0; enable = 1'b1; move_tick = 1'b0; tank_en = 1'b0;
        tank_num = 2'd0; mytank_dir = 2'd0; mytank_xpos = 5'd20; mytank_ypos = 5'd10;
        reward_frozen = 1'b0; reward_laser = 1'b0; bul_busy = 1'b0; fire_ack = 1'b0;
        bullet(1'b0, 5'd0, 5'd0);

        // Reset values
        step();
        push_reset("reset");
        step();
        rst_n = 1'b1;

        // Spawn at corner 1: ALIVE two cycles after tank_en
        tank_num = 2'd1;
        tank_en  = 1'b1;
        push(SEL_STATE, 0, "spawn_lat1");
        step();
        tank_en = 1'b0;
        push(SEL_STATE, 1, "spawn_state");
        push(SEL_X, 24, "spawn_x");
        push(SEL_Y, 0, "spawn_y");
        push(SEL_DIR, 1, "spawn_dir");
        push(SEL_FREQ, 0, "spawn_no_fire");
        step();
        // Immediate bullet hit inside guard window: dies unscored
        bullet(1'b1, 5'd24, 5'd0);
        push(SEL_STATE, 0, "guarded_hit_state");
        push(SEL_KILL, 0, "guarded_hit_kill");
        push(SEL_SCORE, 0, "guarded_hit_score");
        step();
        bullet(1'b0, 5'd0, 5'd0);
        step();

        // Chase table
        bul_busy    = 1'b1;
        mytank_xpos = 5'd3;
        mytank_ypos = 5'd7;
        spawn(2'd0);
        for (int i = 0; i < 11; i++) begin
            mytank_xpos   = 5'(tbl[i].mx);
            mytank_ypos   = 5'(tbl[i].my);
            move_tick     = tbl[i].tick[0];
            reward_frozen = tbl[i].frz[0];
            push(SEL_X, tbl[i].ex, $sformatf("chase%0d_x", i));
            push(SEL_Y, tbl[i].ey, $sformatf("chase%0d_y", i));
            push(SEL_DIR, tbl[i].dir, $sformatf("chase%0d_dir", i));
            step();
        end
        move_tick     = 1'b0;
        reward_frozen = 1'b0;

        // Handshake: enemy (3,0), player (3,7) straight below
        mytank_xpos = 5'd3;
        mytank_ypos = 5'd7;
        bul_busy    = 1'b0;
        push(SEL_FREQ, 1, "req_rise");
        push(SEL_FDIR, 1, "req_dir_down");
        step();
        mytank_xpos = 5'd5;
        mytank_ypos = 5'd0;
        for (int k = 0; k < 5; k++) begin
            push(SEL_FREQ, 1, $sformatf("req_hold%0d", k));
            push(SEL_FDIR, 1, $sformatf("req_dir_hold%0d", k));
            step();
        end
        fire_ack = 1'b1;
        push(SEL_FREQ, 0, "req_drop_after_ack");
        step();
        fire_ack = 1'b0;
        bul_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(SEL_FREQ, 0, $sformatf("req_busy%0d", k));
            step();
        end
        bul_busy = 1'b0;
        push(SEL_FREQ, 1, "req_rerise");
        push(SEL_FDIR, 3, "req_dir_right");
        step();
        fire_ack = 1'b1;
        push(SEL_FREQ, 0, "req_drop2");
        step();
        fire_ack = 1'b0;
        push(SEL_FREQ, 0, "req_ack_gap");
        step();
        push(SEL_FREQ, 1, "req_after_gap");
        step();

        // Hit + fire_ack + move_tick together: scored kill, no step
        fire_ack  = 1'b1;
        move_tick = 1'b1;
        bullet(1'b1, 5'd3, 5'd0);
        push(SEL_STATE, 0, "hit_state");
        push(SEL_X, 3, "hit_no_step_x");
        push(SEL_Y, 0, "hit_no_step_y");
        push(SEL_FREQ, 0, "hit_req_drop");
        push(SEL_KILL, 1, "hit_kill");
        push(SEL_SCORE, 1, "hit_score");
        step();
        fire_ack  = 1'b0;
        move_tick = 1'b0;
        bullet(1'b0, 5'd0, 5'd0);
        for (int k = 1; k < 8; k++) begin
            tank_en = (k == 3);
            push(SEL_KILL, 1, $sformatf("kill_hold%0d", k));
            step();
        end
        tank_en = 1'b0;
        push(SEL_KILL, 0, "kill_release");
        push(SEL_STATE, 0, "dead_after_hold");
        step();
        push(SEL_STATE, 0, "dying_tank_en_ignored");
        step();

        // Guard window: hit on 2nd tick unscored, hit after 5th tick scored
        bul_busy      = 1'b1;
        reward_frozen = 1'b1;
        mytank_xpos   = 5'd20;
        mytank_ypos   = 5'd10;
        spawn(2'd0);
        ticks(1);
        move_tick = 1'b1;
        bullet(1'b1, 5'd0, 5'd0);
        push(SEL_STATE, 0, "guard_hit_state");
        push(SEL_KILL, 0, "guard_hit_kill");
        push(SEL_SCORE, 1, "guard_hit_score");
        step();
        move_tick = 1'b0;
        bullet(1'b0, 5'd0, 5'd0);
        step();
        spawn(2'd0);
        ticks(5);
        bullet(1'b1, 5'd0, 5'd0);
        push(SEL_KILL, 1, "scored_hit_kill");
        push(SEL_SCORE, 2, "scored_hit_score");
        step();
        bullet(1'b0, 5'd0, 5'd0);
        repeat (8) step();

        // Corner 3 spawn and boundary suppression
        reward_frozen = 1'b0;
        mytank_xpos   = 5'd24;
        mytank_ypos   = 5'd5;
        tank_num      = 2'd3;
        tank_en       = 1'b1;
        step();
        tank_en = 1'b0;
        push(SEL_X, 24, "c3_x");
        push(SEL_Y, 12, "c3_y");
        step();
        move_tick = 1'b1;
        push(SEL_Y, 11, "bnd_up_y");
        push(SEL_DIR, 0, "bnd_up_dir");
        step();
        mytank_ypos = 5'd20;
        push(SEL_Y, 12, "bnd_down_y");
        push(SEL_DIR, 1, "bnd_down_dir");
        step();
        push(SEL_Y, 12, "bnd_ymax_hold");
        step();
        mytank_xpos = 5'd30;
        mytank_ypos = 5'd12;
        push(SEL_X, 24, "bnd_xmax_hold");
        push(SEL_DIR, 3, "bnd_xmax_dir");
        step();
        move_tick = 1'b0;

        // Reset in the middle of DYING
        bullet(1'b1, 5'd24, 5'd12);
        push(SEL_KILL, 1, "pre_rst_kill");
        push(SEL_SCORE, 3, "pre_rst_score");
        step();
        bullet(1'b0, 5'd0, 5'd0);
        repeat (2) step();
        rst_n = 1'b0;
        push_reset("mid_dying_rst");
        step();
        rst_n = 1'b1;

        // Score saturation at 127
        reward_frozen = 1'b1;
        mytank_xpos   = 5'd20;
        mytank_ypos   = 5'd10;
        for (int i = 0; i < 128; i++) begin
            spawn(2'd0);
            ticks(4);
            bullet(1'b1, 5'd0, 5'd0);
            if (i == 126) push(SEL_SCORE, 127, "sat_reach");
            if (i == 127) begin
                push(SEL_SCORE, 127, "sat_hold");
                push(SEL_KILL, 1, "sat_kill");
            end
            step();
            bullet(1'b0, 5'd0, 5'd0);
            repeat (9) step();
        end

        // Laser ray: enemy walks to (5,2), player at (5,9) facing up
        reward_frozen = 1'b0;
        mytank_xpos   = 5'd5;
        mytank_ypos   = 5'd9;
        mytank_dir    = 2'd0;
        spawn(2'd0);
        ticks(7);
        push(SEL_X, 5, "laser_pre_x");
        push(SEL_Y, 2, "laser_pre_y");
        step();
        reward_laser = 1'b1;
`ifdef ENYTANK_LASER_EN
        push(SEL_STATE, 0, "laser_kill_state");
        push(SEL_KILL, 1, "laser_kill_kill");
`else
        push(SEL_STATE, 1, "laser_ignored_state");
        push(SEL_KILL, 0, "laser_ignored_kill");
`endif
        step();
        reward_laser = 1'b0;

        // enable low: soft clear, position held
        enable = 1'b0;
        push(SEL_STATE, 0, "soft_clr_state");
        push(SEL_X, 5, "soft_clr_x_hold");
        push(SEL_Y, 2, "soft_clr_y_hold");
        push(SEL_KILL, 0, "soft_clr_kill");
        push(SEL_SCORE, 0, "soft_clr_score");
        push(SEL_FREQ, 0, "soft_clr_fire_req");
        step();
        enable = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_enytank_ctrl_v2
`default_nettype wire

// File: doc/enytank_ctrl_v2.md
Name: enytank_ctrl_v2

Overview:
- Parametrised next-generation enemy-tank controller. Grid size, coordinate width, score width, kill-hold time and spawn protection are all configurable.
- Single clock domain. Movement is paced by a one-cycle move_tick strobe instead of a separate slow clock.
- Bullet launch uses an explicit req/ack handshake.
- One instance per enemy tank; sits between the tank generator, the bullet engine and the VGA/score logic.

Parameters:
- XW, 5, x coordinate width
- YW, 5, y coordinate width
- X_MAX, 24, largest legal x
- Y_MAX, 12, largest legal y
- SCORE_W, 7, score width
- KILL_HOLD, 5000000, cycles the kill output stays high after a scored kill
- SPAWN_GUARD, 4, move_ticks after spawn during which a kill scores nothing

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  game-mode enable; low = soft clear
- move_tick  in  1  one-cycle movement strobe
- tank_en  in  1  respawn permission
- tank_num  in  2  spawn corner: 0=(0,0), 1=(X_MAX,0), 2=(0,Y_MAX), 3=(X_MAX,Y_MAX)
- mytank_xpos  in  XW  player x
- mytank_ypos  in  YW  player y
- mytank_dir  in  2  player direction
- mybul_valid  in  1  player bullet in flight
- mybul_x  in  XW  player bullet x
- mybul_y  in  YW  player bullet y
- reward_frozen  in  1  freeze movement
- reward_laser  in  1  laser reward active
- bul_busy  in  1  own enemy bullet in flight
- fire_ack  in  1  bullet engine accepted the launch
- fire_req  out  1  launch request
- fire_dir  out  2  launch direction
- tank_state  out  1  high only while ALIVE
- enytank_xpos  out  XW  enemy x
- enytank_ypos  out  YW  enemy y
- tank_dir_out  out  2  enemy direction: 00 up, 01 down, 10 left, 11 right
- kill  out  1  scored-kill indicator
- score  out  SCORE_W  kill count

Behaviour:
- Reset (rst_n=0 at a clk edge): state DEAD; position (0,0); tank_dir_out 01; tank_state 0; fire_req 0; kill 0; score 0; guard counter 0; hold counter 0.
- enable=0: same as reset, except position and direction hold.
- FSM states: DEAD, SPAWN, ALIVE, DYING.
  - DEAD: if tank_en=1, go to SPAWN next cycle.
  - SPAWN: one cycle. Load position from the tank_num corner, tank_dir_out=01, guard counter=SPAWN_GUARD. Then go to ALIVE. tank_state rises in the first ALIVE cycle, so latency from tank_en is 2 cycles.
  - ALIVE, hit condition: enemy position equals the player position, or mybul_valid=1 and enemy position equals the bullet position. On a hit go to DYING and drop fire_req.
    - Guard counter 0: score+1, saturating at 2^SCORE_W-1; kill=1; hold counter loaded with KILL_HOLD-1.
    - Guard counter nonzero: no score, kill stays 0; hold counter 0.
  - DYING: decrement the hold counter each cycle. When it reaches 0, clear kill and go to DEAD. A tank_en during DYING is ignored.
- Guard counter: decrements on each move_tick in ALIVE, floor 0.
- Movement: only in ALIVE, on move_tick, with reward_frozen=0. Let dx=|ex-mx| and dy=|ey-my|.
  - Equal positions: no move.
  - dx=0: step y toward the player.
  - dy=0: step x toward the player.
  - Otherwise: if dx<dy step x toward the player, else step y.
  - A step that would leave [0,X_MAX] or [0,Y_MAX] is suppressed; direction still updates.
  - tank_dir_out is set to the step direction. y decreasing = up.
- Fire handshake:
  - In ALIVE with exactly one of dx=0 / dy=0, bul_busy=0 and fire_req=0: assert fire_req next cycle, with fire_dir = direction toward the player.
  - fire_req and fire_dir stay stable until fire_ack=1 is sampled; fire_req drops the following cycle.
  - No new request for one cycle after an ack.
  - Leaving ALIVE drops fire_req with no ack required.
- Simultaneous events:
  - hit and move_tick in the same cycle: hit wins, no move.
  - hit and fire_ack in the same cycle: ack consumed, FSM to DYING.
  - tank_en in ALIVE: ignored.

Optional Feature:
- Macro ENYTANK_LASER_EN.
- Defined: in ALIVE with reward_laser=1, the tank is killed (same path as a hit, guard rules apply) when it lies on the player's ray:
  - mytank_dir=00: same x, ey<my
  - 01: same x, ey>my
  - 10: same y, ex<mx
  - 11: same y, ex>mx
- Not defined: reward_laser is present but ignored.

Decomposition:
- Package enytank_pkg: direction encodings DIR_UP/DOWN/LEFT/RIGHT, FSM state enum, corner-select constants.
- Sub-module enytank_chase: combinational; outputs next position, next direction and the aligned flag from the enemy/player coordinates plus X_MAX/Y_MAX.

Test Plan:
- Spawn: tank_num=1, tank_en pulse → tank_state=1 two cycles later; position (24,0); tank_dir_out=01.
- Chase: enemy (0,0), player (3,7), 3 move_ticks → (3,0) with dir 11; next tick → (3,1) with dir 01; fire_req rises.
- Handshake: hold fire_ack=0 for 5 cycles → fire_req and fire_dir stable; fire_ack=1 → fire_req=0 next cycle; bul_busy=1 → no new request.
- Guard vs scored kill: bullet hit at the 2nd move_tick after spawn → score unchanged, kill stays 0. Hit after the 5th move_tick → score+1, kill high for KILL_HOLD cycles (use KILL_HOLD=8), then DEAD.
- Boundaries: score at 127 plus a hit → stays 127. Hit and move_tick in the same cycle → no step. rst_n low mid-DYING → all outputs at reset values next cycle.
- Laser (ENYTANK_LASER_EN defined): enemy (5,2), player (5,9), mytank_dir=00, reward_laser=1 → DYING next cycle. Macro not defined → enemy unaffected.
